// File: rtl/regfile_defs.sv
// Shared sizing and register index constants for the 8x16 register file.
package regfile_defs;

    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_DEPTH  = 8;

    // Register indices used by benches and the control unit
    localparam logic [REG_ADDR_W-1:0] R0 = 3'd0;
    localparam logic [REG_ADDR_W-1:0] R1 = 3'd1;
    localparam logic [REG_ADDR_W-1:0] R2 = 3'd2;
    localparam logic [REG_ADDR_W-1:0] R3 = 3'd3;
    localparam logic [REG_ADDR_W-1:0] R4 = 3'd4;
    localparam logic [REG_ADDR_W-1:0] R5 = 3'd5;
    localparam logic [REG_ADDR_W-1:0] R6 = 3'd6;
    localparam logic [REG_ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/reg16_ld.sv
// Data register with synchronous active-high reset and load enable.
module reg16_ld
    import regfile_defs::*;
#(
    parameter int unsigned         DATA_W  = REG_DATA_W,
    parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_8x16.sv
// 8x16 register file with one write port, two combinational read ports and
// an N/Z/C status register. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file_8x16
    import regfile_defs::*;
#(
    parameter int unsigned       DATA_W  = REG_DATA_W,
    parameter int unsigned       ADDR_W  = REG_ADDR_W,
    parameter logic [DATA_W-1:0] RST_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_En,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W,
    input  logic [ADDR_W-1:0] R_Addr,
    input  logic [ADDR_W-1:0] S_Addr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    input  logic              Flag_En,
    input  logic              N_In,
    input  logic              Z_In,
    input  logic              C_In,
    output logic              N_Q,
    output logic              Z_Q,
    output logic              C_Q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  ld;
    logic [DATA_W-1:0] q [DEPTH];
    logic [2:0]        flags;

    // Write address decode gated by the write enable
    always_comb begin
        ld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld[i] = W_En && (W_Addr == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        reg16_ld #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .ld    (ld[g]),
            .d     (W),
            .q     (q[g])
        );
    end

    // Read muxes; forwarding is held off during reset so reads stay on stored state
    always_comb begin
        R = q[R_Addr];
        S = q[S_Addr];
`ifdef REGFILE_BYPASS_EN
        if (W_En && !reset && (W_Addr == R_Addr)) begin
            R = W;
        end
        if (W_En && !reset && (W_Addr == S_Addr)) begin
            S = W;
        end
`endif
    end

    // Status register: same load-register pattern, 3 bits wide
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 3'b000;
        end else if (Flag_En) begin
            flags <= {N_In, Z_In, C_In};
        end
    end

    assign N_Q = flags[2];
    assign Z_Q = flags[1];
    assign C_Q = flags[0];

endmodule

// File: tb/tb_reg_file_8x16.sv
// Scoreboard bench for reg_file_8x16: stimulus queues expected R/S/flags,
// a negedge monitor pops and compares whenever a check strobe is raised.
module tb_reg_file_8x16;
    import regfile_defs::*;

    logic        clk;
    logic        reset;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [15:0] w;
    logic [2:0]  r_addr;
    logic [2:0]  s_addr;
    logic [15:0] r;
    logic [15:0] s;
    logic        flag_en;
    logic        n_in, z_in, c_in;
    logic        n_q, z_q, c_q;

    typedef struct {
        string       name;
        logic [15:0] r;
        logic [15:0] s;
        logic [2:0]  nzc;
    } exp_t;

    exp_t exp_q[$];
    logic chk;
    logic end_req;
    logic mon_done;
    int   n_tests;
    int   n_fail;

    reg_file_8x16 dut (
        .clk     (clk),
        .reset   (reset),
        .W_En    (w_en),
        .W_Addr  (w_addr),
        .W       (w),
        .R_Addr  (r_addr),
        .S_Addr  (s_addr),
        .R       (r),
        .S       (s),
        .Flag_En (flag_en),
        .N_In    (n_in),
        .Z_In    (z_in),
        .C_In    (c_in),
        .N_Q     (n_q),
        .Z_Q     (z_q),
        .C_Q     (c_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares popped expectations against the DUT on the falling edge
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        mon_done = 1'b0;
        forever begin
            @(negedge clk);
            if (chk) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: check strobe with no expectation queued");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_tests++;
                    if (r !== e.r) begin
                        n_fail++;
                        $display("FAIL %s R: got %h, expected %h", e.name, r, e.r);
                    end
                    n_tests++;
                    if (s !== e.s) begin
                        n_fail++;
                        $display("FAIL %s S: got %h, expected %h", e.name, s, e.s);
                    end
                    n_tests++;
                    if ({n_q, z_q, c_q} !== e.nzc) begin
                        n_fail++;
                        $display("FAIL %s NZC: got %b, expected %b", e.name, {n_q, z_q, c_q}, e.nzc);
                    end
                end
            end
            if (end_req && !mon_done) begin
                n_tests++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL sb_drain: %0d expectations left, expected 0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation and strobe the monitor for the current cycle
    task automatic check(input string name, input logic [15:0] er, input logic [15:0] es,
                         input logic [2:0] enzc);
        exp_t e;
        e.name = name;
        e.r    = er;
        e.s    = es;
        e.nzc  = enzc;
        exp_q.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        tick();
        w_en   = 1'b1;
        w_addr = a;
        w      = d;
        tick();
        w_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk = 1'b0; end_req = 1'b0;
        reset = 1'b1; w_en = 1'b0; w_addr = '0; w = '0;
        r_addr = '0; s_addr = '0;
        flag_en = 1'b0; n_in = 1'b0; z_in = 1'b0; c_in = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // 1: fill with FFFF, reset one cycle, everything reads back zero
        for (int a = 0; a < REG_DEPTH; a++) write(3'(a), 16'hFFFF);
        r_addr = R0; s_addr = R7;
        check("fill", 16'hFFFF, 16'hFFFF, 3'b000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < REG_DEPTH; a++) begin
            r_addr = 3'(a);
            s_addr = 3'(7 - a);
            check($sformatf("reset_a%0d", a), 16'h0000, 16'h0000, 3'b000);
        end

        // 2: operand pair
        write(R1, 16'h1111);
        write(R2, 16'h1110);
        r_addr = R1; s_addr = R2;
        check("pair", 16'h1111, 16'h1110, 3'b000);

        // 3: same-cycle write and read of reg3
        tick();
        r_addr = R3; s_addr = R0;
        w_en = 1'b1; w_addr = R3; w = 16'hABCD;
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_pre", 16'hABCD, 16'h0000, 3'b000);
`else
        check("same_cyc_pre", 16'h0000, 16'h0000, 3'b000);
`endif
        tick();
        w_en = 1'b0;
        check("same_cyc_post", 16'hABCD, 16'h0000, 3'b000);

        // Write and flag load in the same cycle
        tick();
        w_en = 1'b1; w_addr = R5; w = 16'h0F0F;
        flag_en = 1'b1; n_in = 1'b0; z_in = 1'b1; c_in = 1'b0;
        tick();
        w_en = 1'b0; flag_en = 1'b0; z_in = 1'b0;
        r_addr = R5; s_addr = R3;
        check("wr_and_flag", 16'h0F0F, 16'hABCD, 3'b010);

        // 4: reset beats write and flag load
        tick();
        flag_en = 1'b1; n_in = 1'b1; z_in = 1'b1; c_in = 1'b1;
        tick();
        flag_en = 1'b0;
        check("flags_set", 16'h0F0F, 16'hABCD, 3'b111);
        tick();
        reset = 1'b1; w_en = 1'b1; w_addr = R4; w = 16'h5A5A; flag_en = 1'b1;
        r_addr = R4; s_addr = R1;
        check("rst_prio_pre", 16'h0000, 16'h1111, 3'b111);
        tick();
        reset = 1'b0; w_en = 1'b0; flag_en = 1'b0;
        n_in = 1'b0; z_in = 1'b0; c_in = 1'b0;
        check("rst_prio_post", 16'h0000, 16'h0000, 3'b000);

        // 5: flag load then hold
        tick();
        flag_en = 1'b1; n_in = 1'b1; z_in = 1'b0; c_in = 1'b1;
        tick();
        flag_en = 1'b0; n_in = 1'b0; c_in = 1'b0;
        check("flags_101", 16'h0000, 16'h0000, 3'b101);
        tick();
        check("flags_hold", 16'h0000, 16'h0000, 3'b101);

        // 6: both ports on reg7, then a disabled write leaves it alone
        write(R7, 16'h8000);
        r_addr = R7; s_addr = R7;
        check("same_addr", 16'h8000, 16'h8000, 3'b101);
        tick();
        w_en = 1'b0; w_addr = R7; w = 16'h1234;
        tick();
        check("wen_low", 16'h8000, 16'h8000, 3'b101);

        end_req = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) tick();
        if (!mon_done) $display("FAIL monitor_drain: monitor did not finish within bound");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
